// File: rtl/v_upd_ingress.sv
// +--------------------------------------------------------------------------+
// | v_upd_ingress : update-command FIFO and gap-paced issue controller that  |
// | feeds the list engine's update bus.                                      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package v_pkg;
  typedef logic [7:0]  id_t;
  typedef logic [3:0]  cmd_t;
  typedef logic [31:0] key_t;
  typedef logic [15:0] size_t;
endpackage

module v_upd_ingress #(
  parameter int DEPTH     = 8,
  parameter int ISSUE_GAP = 1,
  parameter int GAP_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_in_vld,
  output logic                     o_in_rdy,
  input  v_pkg::id_t               i_in_prod_id,
  input  v_pkg::cmd_t              i_in_cmd,
  input  v_pkg::key_t              i_in_key,
  input  v_pkg::size_t             i_in_size,
  input  logic                     i_busy_r,
  input  logic                     i_flush,
  output logic                     o_upd_vld_r,
  output v_pkg::id_t               o_upd_prod_id_r,
  output v_pkg::cmd_t              o_upd_cmd_r,
  output v_pkg::key_t              o_upd_key_r,
  output v_pkg::size_t             o_upd_size_r,
  output logic [$clog2(DEPTH):0]   o_occupancy_r,
  output logic                     o_empty,
  output logic                     o_ovf_r,
  output logic [31:0]              o_issue_cnt_r
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_OW = c_AW + 1;

  typedef struct packed {
    v_pkg::id_t   prod_id;
    v_pkg::cmd_t  cmd;
    v_pkg::key_t  key;
    v_pkg::size_t size;
  } entry_t;

  entry_t            r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [GAP_W-1:0]  r_gap;
  logic              w_full;
  logic              w_push;
  logic              w_issue;
  entry_t            w_head;
  entry_t            w_in;

  // Full/empty come from the occupancy register so that issue never depends
  // combinationally on the upstream inputs.
  assign w_full   = (o_occupancy_r == c_OW'(DEPTH));
  assign o_empty  = (o_occupancy_r == '0);
  assign o_in_rdy = rst_n & ~w_full & ~i_flush;
  assign w_push   = i_in_vld & o_in_rdy;
  assign w_issue  = ~o_empty & ~i_busy_r & (r_gap == '0) & ~i_flush;
  assign w_head   = r_mem[r_rd_ptr];
  assign w_in     = '{prod_id: i_in_prod_id, cmd: i_in_cmd, key: i_in_key, size: i_in_size};

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_gap           <= '0;
      o_occupancy_r   <= '0;
      o_upd_vld_r     <= 1'b0;
      o_upd_prod_id_r <= '0;
      o_upd_cmd_r     <= '0;
      o_upd_key_r     <= '0;
      o_upd_size_r    <= '0;
      o_ovf_r         <= 1'b0;
      o_issue_cnt_r   <= '0;
    end else begin
      if (i_in_vld && !o_in_rdy) begin
        o_ovf_r <= 1'b1;
      end

      o_upd_vld_r <= w_issue;
      if (w_issue) begin
        o_upd_prod_id_r <= w_head.prod_id;
        o_upd_cmd_r     <= w_head.cmd;
        o_upd_key_r     <= w_head.key;
        o_upd_size_r    <= w_head.size;
        r_gap           <= GAP_W'(ISSUE_GAP);
        if (o_issue_cnt_r != 32'hFFFF_FFFF) begin
          o_issue_cnt_r <= o_issue_cnt_r + 32'd1;
        end
      end else if (r_gap != '0) begin
        r_gap <= r_gap - 1'b1;
      end

      if (i_flush) begin
        r_wr_ptr      <= '0;
        r_rd_ptr      <= '0;
        o_occupancy_r <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_issue) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_push && !w_issue) begin
          o_occupancy_r <= o_occupancy_r + 1'b1;
        end else if (!w_push && w_issue) begin
          o_occupancy_r <= o_occupancy_r - 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_v_upd_ingress.sv
// +--------------------------------------------------------------------------+
// | tb_v_upd_ingress : directed and random stimulus against a queue model.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_v_upd_ingress;

  localparam int c_DEPTH     = 8;
  localparam int c_ISSUE_GAP = 1;
  localparam int c_GAP_W     = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_in_vld;
  logic          o_in_rdy;
  v_pkg::id_t    i_in_prod_id;
  v_pkg::cmd_t   i_in_cmd;
  v_pkg::key_t   i_in_key;
  v_pkg::size_t  i_in_size;
  logic          i_busy_r;
  logic          i_flush;
  logic          o_upd_vld_r;
  v_pkg::id_t    o_upd_prod_id_r;
  v_pkg::cmd_t   o_upd_cmd_r;
  v_pkg::key_t   o_upd_key_r;
  v_pkg::size_t  o_upd_size_r;
  logic [3:0]    o_occupancy_r;
  logic          o_empty;
  logic          o_ovf_r;
  logic [31:0]   o_issue_cnt_r;

  v_upd_ingress #(.DEPTH(c_DEPTH), .ISSUE_GAP(c_ISSUE_GAP), .GAP_W(c_GAP_W)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_in_vld        (i_in_vld),
    .o_in_rdy        (o_in_rdy),
    .i_in_prod_id    (i_in_prod_id),
    .i_in_cmd        (i_in_cmd),
    .i_in_key        (i_in_key),
    .i_in_size       (i_in_size),
    .i_busy_r        (i_busy_r),
    .i_flush         (i_flush),
    .o_upd_vld_r     (o_upd_vld_r),
    .o_upd_prod_id_r (o_upd_prod_id_r),
    .o_upd_cmd_r     (o_upd_cmd_r),
    .o_upd_key_r     (o_upd_key_r),
    .o_upd_size_r    (o_upd_size_r),
    .o_occupancy_r   (o_occupancy_r),
    .o_empty         (o_empty),
    .o_ovf_r         (o_ovf_r),
    .o_issue_cnt_r   (o_issue_cnt_r)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {prod_id, cmd, key, size} words plus the
  // number of non-issuing edges since the last issue.
  logic [59:0] m_q[$];
  logic [59:0] m_last;
  int          m_idle;
  bit          m_ovf;
  longint      m_cnt;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [59:0] mk(input logic [31:0] key);
    logic [7:0]  id = 8'($urandom);
    logic [3:0]  cm = 4'($urandom);
    logic [15:0] sz = 16'($urandom);
    return {id, cm, key, sz};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_last = '0;
    m_idle = c_ISSUE_GAP;
    m_ovf  = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic check_outputs();
    chk("upd_vld",  {63'd0, o_upd_vld_r}, {63'd0, 1'b0});
    chk("fields",   {4'd0, o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_size_r}, {4'd0, m_last});
    chk("occupancy", 64'(o_occupancy_r), 64'(m_q.size()));
    chk("empty",    64'(o_empty), 64'(m_q.size() == 0));
    chk("ovf",      64'(o_ovf_r), 64'(m_ovf));
    chk("issue_cnt", 64'(o_issue_cnt_r), 64'(m_cnt));
  endtask

  // One clock: drive inputs, predict the edge, then compare after it.
  task automatic step(input bit a_vld, input logic [59:0] a_d, input bit a_busy, input bit a_flush);
    bit exp_rdy;
    bit exp_iss;
    {i_in_prod_id, i_in_cmd, i_in_key, i_in_size} = a_d;
    i_in_vld = a_vld;
    i_busy_r = a_busy;
    i_flush  = a_flush;
    #1;
    exp_rdy = (m_q.size() < c_DEPTH) && !a_flush;
    chk("in_rdy", 64'(o_in_rdy), 64'(exp_rdy));
    exp_iss = (m_q.size() > 0) && !a_busy && (m_idle >= c_ISSUE_GAP) && !a_flush;
    if (a_vld && !exp_rdy) m_ovf = 1'b1;
    if (a_flush) begin
      m_q.delete();
    end else begin
      if (exp_iss) begin
        m_last = m_q.pop_front();
        if (m_cnt != 64'hFFFF_FFFF) m_cnt++;
      end
      if (a_vld && exp_rdy) m_q.push_back(a_d);
    end
    m_idle = exp_iss ? 0 : ((m_idle < 1000) ? m_idle + 1 : m_idle);
    @(posedge clk);
    #1;
    chk("upd_vld", 64'(o_upd_vld_r), 64'(exp_iss));
    chk("fields", {4'd0, o_upd_prod_id_r, o_upd_cmd_r, o_upd_key_r, o_upd_size_r}, {4'd0, m_last});
    chk("occupancy", 64'(o_occupancy_r), 64'(m_q.size()));
    chk("empty", 64'(o_empty), 64'(m_q.size() == 0));
    chk("ovf", 64'(o_ovf_r), 64'(m_ovf));
    chk("issue_cnt", 64'(o_issue_cnt_r), 64'(m_cnt));
  endtask

  task automatic idle(input int n, input bit a_busy);
    for (int i = 0; i < n; i++) step(1'b0, 60'd0, a_busy, 1'b0);
  endtask

  task automatic mid_reset();
    rst_n    = 1'b0;
    i_in_vld = 1'b1;
    #1;
    model_reset();
    chk("rst_in_rdy", 64'(o_in_rdy), 64'd0);
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    i_in_vld = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    i_in_vld = 1'b0; i_busy_r = 1'b0; i_flush = 1'b0;
    i_in_prod_id = '0; i_in_cmd = '0; i_in_key = '0; i_in_size = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_rdy", 64'(o_in_rdy), 64'd0);
    check_outputs();
    rst_n = 1'b1;

    // Single update to an idle engine.
    step(1'b1, {8'd2, 4'd1, 32'h10, 16'd5}, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Back-to-back pushes paced by the gap.
    for (int k = 0; k < 3; k++) step(1'b1, mk(32'(k)), 1'b0, 1'b0);
    idle(6, 1'b0);

    // Busy stall with four pending entries.
    for (int k = 0; k < 4; k++) step(1'b1, mk(32'(100 + k)), 1'b1, 1'b0);
    idle(6, 1'b1);
    idle(10, 1'b0);

    // Fill to DEPTH, push once more while full, then drain.
    for (int k = 0; k < c_DEPTH + 1; k++) step(1'b1, mk(32'(200 + k)), 1'b1, 1'b0);
    idle(20, 1'b0);

    // Wrap-around: keys 0..19 streamed through the FIFO.
    for (int k = 0; k < 20; k++) begin
      step(1'b1, mk(32'(k)), 1'b0, 1'b0);
      step(1'b0, 60'd0, 1'b0, 1'b0);
    end
    idle(4, 1'b0);

    // Flush with a concurrent push attempt.
    for (int k = 0; k < 5; k++) step(1'b1, mk(32'(300 + k)), 1'b1, 1'b0);
    step(1'b1, mk(32'h999), 1'b0, 1'b1);
    idle(4, 1'b0);

    // Reset mid-stream.
    for (int k = 0; k < 3; k++) step(1'b1, mk(32'(400 + k)), 1'b1, 1'b0);
    mid_reset();
    idle(5, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(99) < 70), mk($urandom), ($urandom_range(99) < 30),
           ($urandom_range(99) < 3));
    end
    idle(20, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
